// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external single-port-per-direction RAM with
// a one-cycle registered read. Words are written straight into the RAM; the
// output stage prefetches one word into a holding register so the consumer
// sees a registered out_data with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   in_valid/in_ready/in_data     producer handshake and write data
//   out_valid/out_ready/out_data  consumer handshake and registered read word
//   ram_wr_en/ram_wr_addr/ram_wr_data  RAM write port
//   ram_rd_en/ram_rd_addr/ram_rd_data  RAM read port (data one clk after ram_rd_en)
//   level             words resident in RAM (excludes the word held in out_data)
//   full, empty       level == RAM_DEPTH; nothing in RAM and output stage idle
module ram_fifo_ctrl #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned RAM_DEPTH = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RAM_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RAM_WIDTH-1:0] out_data,
  output logic                 ram_wr_en,
  output logic [ADDR_W-1:0]    ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_W-1:0]    ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_W:0]      level,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_W:0]   DepthL   = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0]   OneL     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] OneA     = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        level_q, level_d;
  logic [RAM_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   do_wr, do_rd;

  // Reads are only issued for words already counted in level_q, so a word
  // written this cycle is never read back in the same cycle.
  always_comb begin
    in_ready = rst && (level_q < DepthL);
    do_wr    = in_valid && in_ready;
    do_rd    = rst && (level_q != '0) &&
               ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  end

  always_comb begin
    ram_wr_en   = do_wr;
    ram_wr_addr = rst ? wr_ptr_q : '0;
    ram_wr_data = in_data;
    ram_rd_en   = do_rd;
    ram_rd_addr = rst ? rd_ptr_q : '0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    state_d    = state_q;
    out_data_d = out_data_q;

    if (do_wr) wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + OneA;
    if (do_rd) rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + OneA;

    if (do_wr && !do_rd) begin
      level_d = level_q + OneL;
    end else if (do_rd && !do_wr) begin
      level_d = level_q - OneL;
    end

    unique case (state_q)
      StIdle: begin
        if (do_rd) state_d = StFetch;
      end
      StFetch: begin
        state_d    = StHold;
        out_data_d = ram_rd_data;
      end
      StHold: begin
        if (out_ready) state_d = do_rd ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    out_valid = (state_q == StHold);
    out_data  = out_data_q;
    level     = level_q;
    full      = (level_q == DepthL);
    empty     = (level_q == '0) && (state_q == StIdle);
  end

endmodule
